// File: rtl/lab2_proc_pkg.sv
// Shared definitions for the lab2 processor divide unit: fn codes, request
// field offsets and the control FSM state encoding.
package lab2_proc_pkg;

    localparam logic [1:0] FN_DIV  = 2'd0;
    localparam logic [1:0] FN_DIVU = 2'd1;
    localparam logic [1:0] FN_REM  = 2'd2;
    localparam logic [1:0] FN_REMU = 2'd3;

    localparam int MSG_B_LSB  = 0;
    localparam int MSG_A_LSB  = 32;
    localparam int MSG_FN_LSB = 64;
    localparam int MSG_W      = 66;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Even fn codes (DIV, REM) are the signed variants.
    function automatic logic is_signed_op(input logic [1:0] fn);
        return ~fn[0];
    endfunction

endpackage

// File: rtl/lab2_proc_int_div_dpath.sv
// Divider datapath: operand magnitudes, {rem,quo} restoring shift register, iteration
// counter, sign fix-up and result mux. One quotient bit per shift; no backpressure of its own.
module lab2_proc_int_div_dpath
    import lab2_proc_pkg::*;
(
    input  logic        clk,
    input  logic        load,
    input  logic        shift,
    input  logic        zero_div,
    input  logic [1:0]  req_fn,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        cnt_zero,
    output logic [31:0] result
);

    logic [1:0]  fn_q;
    logic [31:0] a_raw_q;
    logic [31:0] b_mag_q;
    logic        quo_neg_q;
    logic        rem_neg_q;
    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [4:0]  cnt_q;

    logic        signed_op;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [63:0] shifted;
    logic [32:0] diff;
    logic [31:0] quo_res;
    logic [31:0] rem_res;

    assign signed_op = is_signed_op(req_fn);
    assign a_mag     = (signed_op && req_a[31]) ? -req_a : req_a;
    assign b_mag     = (signed_op && req_b[31]) ? -req_b : req_b;

    // The partial remainder is below 2^31 before every shift, so 32 bits plus
    // a borrow bit in the difference are enough.
    assign shifted = {rem_q, quo_q} << 1;
    assign diff    = {1'b0, shifted[63:32]} - {1'b0, b_mag_q};

    always_ff @(posedge clk) begin
        if (load) begin
            fn_q      <= req_fn;
            a_raw_q   <= req_a;
            b_mag_q   <= b_mag;
            quo_neg_q <= signed_op && (req_a[31] ^ req_b[31]);
            rem_neg_q <= signed_op && req_a[31];
            rem_q     <= '0;
            quo_q     <= a_mag;
            cnt_q     <= 5'd31;
        end else if (shift) begin
            if (!diff[32]) begin
                rem_q <= diff[31:0];
                quo_q <= {shifted[31:1], 1'b1};
            end else begin
                rem_q <= shifted[63:32];
                quo_q <= shifted[31:0];
            end
            cnt_q <= cnt_q - 5'd1;
        end
    end

    assign cnt_zero = (cnt_q == 5'd0);

    assign quo_res = zero_div ? 32'hFFFF_FFFF : (quo_neg_q ? -quo_q : quo_q);
    assign rem_res = zero_div ? a_raw_q       : (rem_neg_q ? -rem_q : rem_q);
    assign result  = fn_q[1] ? rem_res : quo_res;

endmodule

// File: rtl/lab2_proc_int_div_unit.sv
// Iterative DIV/DIVU/REM/REMU unit: 33 cycles accept-to-result (1 on divide by zero).
// One request in flight; result held in DONE until ostream_rdy, istream_rdy only in IDLE.
module lab2_proc_int_div_unit
    import lab2_proc_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              istream_val,
    output logic              istream_rdy,
    input  logic [MSG_W-1:0]  istream_msg,
    output logic              ostream_val,
    input  logic              ostream_rdy,
    output logic [31:0]       ostream_msg
);

    div_state_t  state;
    div_state_t  state_next;
    logic        load;
    logic        shift;
    logic        zero_div_q;
    logic        cnt_zero;
    logic        b_zero;
    logic [1:0]  req_fn;
    logic [31:0] req_a;
    logic [31:0] req_b;

    assign req_fn = istream_msg[MSG_FN_LSB +: 2];
    assign req_a  = istream_msg[MSG_A_LSB  +: 32];
    assign req_b  = istream_msg[MSG_B_LSB  +: 32];
    assign b_zero = (req_b == 32'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            zero_div_q <= 1'b0;
        end else begin
            state <= state_next;
            if (load) begin
                zero_div_q <= b_zero;
            end
        end
    end

    always_comb begin
        state_next  = state;
        istream_rdy = 1'b0;
        ostream_val = 1'b0;
        load        = 1'b0;
        shift       = 1'b0;
        case (state)
            IDLE: begin
                istream_rdy = !reset;
                load        = !reset && istream_val;
                if (load) begin
                    state_next = b_zero ? DONE : CALC;
                end
            end
            CALC: begin
                shift = !reset;
                if (cnt_zero) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                ostream_val = !reset;
                if (ostream_rdy) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    lab2_proc_int_div_dpath u_dpath (
        .clk      (clk),
        .load     (load),
        .shift    (shift),
        .zero_div (zero_div_q),
        .req_fn   (req_fn),
        .req_a    (req_a),
        .req_b    (req_b),
        .cnt_zero (cnt_zero),
        .result   (ostream_msg)
    );

endmodule

// File: tb/tb_lab2_proc_int_div_unit.sv
// Directed and randomized checks of the divide unit against an arithmetic reference model.
module tb_lab2_proc_int_div_unit;
    import lab2_proc_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              istream_val;
    logic              istream_rdy;
    logic [MSG_W-1:0]  istream_msg;
    logic              ostream_val;
    logic              ostream_rdy;
    logic [31:0]       ostream_msg;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    lab2_proc_int_div_unit dut (
        .clk         (clk),
        .reset       (reset),
        .istream_val (istream_val),
        .istream_rdy (istream_rdy),
        .istream_msg (istream_msg),
        .ostream_val (ostream_val),
        .ostream_rdy (ostream_rdy),
        .ostream_msg (ostream_msg)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: RISC-V M semantics via 64-bit arithmetic (truncating division).
    function automatic logic [31:0] model(input logic [1:0] fn, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = 0;
        case (fn)
            FN_DIV:  r = (b == 0) ? -1 : sa / sb;
            FN_DIVU: r = (b == 0) ? -1 : longint'(a) / longint'(b);
            FN_REM:  r = (b == 0) ? longint'(a) : sa % sb;
            default: r = (b == 0) ? longint'(a) : longint'(a) % longint'(b);
        endcase
        return r[31:0];
    endfunction

    function automatic logic [MSG_W-1:0] mk_msg(input logic [1:0] fn, input logic [31:0] a,
                                                input logic [31:0] b);
        logic [MSG_W-1:0] m;
        m = '0;
        m[MSG_FN_LSB +: 2] = fn;
        m[MSG_A_LSB  +: 32] = a;
        m[MSG_B_LSB  +: 32] = b;
        return m;
    endfunction

    // Presents a request and returns just after the accept edge with the inputs scrambled.
    task automatic issue(input logic [1:0] fn, input logic [31:0] a, input logic [31:0] b);
        int guard;
        @(negedge clk);
        istream_val = 1'b1;
        istream_msg = mk_msg(fn, a, b);
        guard = 0;
        while (!istream_rdy && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) check("issue_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        istream_val = 1'b0;
        istream_msg = {$urandom, $urandom, $urandom};
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ostream_val && lat < 200);
    endtask

    task automatic drain();
        ostream_rdy = 1'b1;
        @(posedge clk);
        #1;
        ostream_rdy = 1'b0;
    endtask

    task automatic directed(input string tag, input logic [1:0] fn, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        issue(fn, a, b);
        wait_result(lat);
        check({tag, "_lat"}, lat, exp_lat);
        check(tag, ostream_msg, exp);
        check({tag, "_irdy"}, {31'd0, istream_rdy}, 32'd0);
        drain();
    endtask

    initial begin
        int lat;
        reset       = 1'b1;
        istream_val = 1'b0;
        istream_msg = '0;
        ostream_rdy = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_irdy", {31'd0, istream_rdy}, 32'd0);
        check("reset_oval", {31'd0, ostream_val}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_irdy", {31'd0, istream_rdy}, 32'd1);
        check("idle_oval", {31'd0, ostream_val}, 32'd0);

        directed("div_20_3",    FN_DIV,  32'd20, 32'd3, 32'd6, 33);
        directed("rem_20_3",    FN_REM,  32'd20, 32'd3, 32'd2, 33);
        directed("divu_max_2",  FN_DIVU, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 33);
        directed("remu_max_2",  FN_REMU, 32'hFFFF_FFFF, 32'd2, 32'd1, 33);
        directed("div_m20_3",   FN_DIV,  -32'sd20, 32'd3, 32'hFFFF_FFFA, 33);
        directed("rem_m20_3",   FN_REM,  -32'sd20, 32'd3, 32'hFFFF_FFFE, 33);
        directed("div_20_m3",   FN_DIV,  32'd20, -32'sd3, 32'hFFFF_FFFA, 33);
        directed("rem_20_m3",   FN_REM,  32'd20, -32'sd3, 32'd2, 33);
        directed("div_7_0",     FN_DIV,  32'd7, 32'd0, 32'hFFFF_FFFF, 1);
        directed("divu_7_0",    FN_DIVU, 32'd7, 32'd0, 32'hFFFF_FFFF, 1);
        directed("rem_m7_0",    FN_REM,  -32'sd7, 32'd0, 32'hFFFF_FFF9, 1);
        directed("remu_7_0",    FN_REMU, 32'd7, 32'd0, 32'd7, 1);
        directed("div_ovf",     FN_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
        directed("rem_ovf",     FN_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);

        // Result must hold under sink backpressure.
        issue(FN_DIV, 32'd100, -32'sd7);
        wait_result(lat);
        check("bp_lat", lat, 33);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_msg",  ostream_msg, 32'hFFFF_FFF2);
            check("bp_oval", {31'd0, ostream_val}, 32'd1);
            check("bp_irdy", {31'd0, istream_rdy}, 32'd0);
        end
        drain();
        @(negedge clk);
        check("bp_after_irdy", {31'd0, istream_rdy}, 32'd1);

        // Reset in CALC cycle 10 discards the in-flight divide.
        issue(FN_DIVU, 32'd1000, 32'd3);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_calc_oval", {31'd0, ostream_val}, 32'd0);
        check("rst_calc_irdy", {31'd0, istream_rdy}, 32'd1);
        directed("divu_100_7", FN_DIVU, 32'd100, 32'd7, 32'd14, 33);

        // Randomized traffic with random source and sink delays.
        fork
            begin : producer
                for (int i = 0; i < 30; i++) begin
                    logic [1:0]  fn;
                    logic [31:0] a, b;
                    fn = 2'($urandom_range(0, 3));
                    a  = $urandom;
                    case ($urandom_range(0, 5))
                        0: b = 32'd0;
                        1: b = $urandom_range(1, 15);
                        2: b = 32'hFFFF_FFFF - $urandom_range(0, 15);
                        3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                        default: b = $urandom;
                    endcase
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    issue(fn, a, b);
                    exp_q.push_back(model(fn, a, b));
                end
            end
            begin : consumer
                for (int i = 0; i < 30; i++) begin
                    logic [31:0] got;
                    logic [31:0] want;
                    wait_result(lat);
                    if (!ostream_val) begin
                        check("rand_timeout", 32'd0, 32'd1);
                        break;
                    end
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    got = ostream_msg;
                    drain();
                    if (exp_q.size() == 0) begin
                        check("rand_unexpected", got, 32'hDEAD_BEEF);
                    end else begin
                        want = exp_q.pop_front();
                        check("rand_result", got, want);
                    end
                end
            end
        join

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule
